// File: rtl/sub_bytes_seq.sv
// AES SubBytes over a 128-bit state, streamed through LANES registered sbox ROMs.
// One state in flight: IDLE -> ISSUE (N groups) -> DRAIN -> DONE -> IDLE.

module sub_bytes_seq_sbox (
  input  logic       clk_i,
  input  logic [7:0] addr_i,
  output logic [7:0] dout_o
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_ff @(posedge clk_i) begin
    dout_o <= SBOX[addr_i];
  end

endmodule

module sub_bytes_seq #(
  parameter int unsigned LANES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned N    = 16 / LANES;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte 0 is the most significant byte of the 128-bit word.
  typedef logic [0:15][7:0] blk_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] wr_idx_q, wr_idx_d;
  logic            pipe_vld_q, pipe_vld_d;
  blk_t            in_buf_q;
  blk_t            result_q, result_d;
  blk_t            out_state_q;

  logic [7:0] sb_addr [LANES];
  logic [7:0] sb_dout [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign sb_addr[j] = in_buf_q[4'(32'(idx_q) * LANES + 32'(j))];

    sub_bytes_seq_sbox u_sbox (
      .clk_i  (clk),
      .addr_i (sb_addr[j]),
      .dout_o (sb_dout[j])
    );
  end

  // Sbox outputs are only merged when pipe_vld_q marks them as a real issue.
  always_comb begin
    result_d = result_q;
    if (pipe_vld_q) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        result_d[4'(32'(wr_idx_q) * LANES + j)] = sb_dout[j];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_idx_d   = idx_q;
    pipe_vld_d = (state_q == ISSUE);
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ISSUE;
          idx_d   = '0;
        end
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wr_idx_q    <= '0;
      pipe_vld_q  <= 1'b0;
      out_state_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_idx_q   <= wr_idx_d;
      pipe_vld_q <= pipe_vld_d;
      if (state_q == DRAIN) begin
        out_state_q <= result_d;
      end
    end
  end

  // Datapath registers need no reset: every byte is rewritten before use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      in_buf_q <= in_state;
    end
    result_q <= result_d;
  end

  assign out_state = out_state_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench for sub_bytes_seq: LANES=1 main instance plus a LANES=4 instance.
// Expected results come from an arithmetic GF(2^8) sbox model and FIPS constants.

module tb_sub_bytes_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_state, out_state;
  logic         in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [127:0] in_state4, out_state4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] sb_q[$];

  localparam int N1 = 16;

  sub_bytes_seq #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .busy(busy)
  );

  sub_bytes_seq #(.LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_state(in_state4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_state(out_state4), .busy(busy4)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] st);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_ref(st[127-8*k -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a state to dut1 and return just after its accepting edge.
  task automatic send1(input logic [127:0] st);
    int w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    if (w >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    in_state = st;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb_q.push_back(ref_sub(st));
  endtask

  task automatic wait_out1(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; in_state4 = '0;
    repeat (3) tick();
    n_tests++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl1: got rdy/vld/busy=%b, required 100", {in_ready, out_valid, busy});
    end
    n_tests++;
    if (out_state !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_out1: got %h, required 0", out_state);
    end
    n_tests++;
    if ({in_ready4, out_valid4, busy4, |out_state4} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_dut4: got rdy/vld/busy/|out=%b, required 1000",
               {in_ready4, out_valid4, busy4, |out_state4});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fips();
    int lat;
    logic [127:0] exp;
    send1(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    n_tests++;
    if ({busy, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL fips_busy: got busy/rdy=%b, required 10", {busy, in_ready});
    end
    wait_out1(lat);
    n_tests++;
    if (lat !== 17) begin
      n_fail++;
      $display("FAIL fips_latency: got %0d, required 17", lat);
    end
    exp = sb_q.pop_front();
    n_tests++;
    if (out_state !== 128'hd42711aee0bf98f1b8b45de51e415230 || out_state !== exp) begin
      n_fail++;
      $display("FAIL fips_value: got %h, required d42711aee0bf98f1b8b45de51e415230", out_state);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, in_ready, busy} !== 3'b010 || out_state !== exp) begin
      n_fail++;
      $display("FAIL fips_release: got vld/rdy/busy=%b out=%h, required 010 out=%h",
               {out_valid, in_ready, busy}, out_state, exp);
    end
  endtask

  task automatic test_patterns();
    logic [127:0] pats [2];
    logic [127:0] exps [2];
    int lat;
    logic [127:0] exp;
    pats[0] = '0; exps[0] = {16{8'h63}};
    pats[1] = '1; exps[1] = {16{8'h16}};
    for (int p = 0; p < 2; p++) begin
      send1(pats[p]);
      wait_out1(lat);
      exp = sb_q.pop_front();
      n_tests++;
      if (lat !== 17 || out_state !== exps[p] || exp !== exps[p]) begin
        n_fail++;
        $display("FAIL pattern%0d_l1: got lat=%0d out=%h, required lat=17 out=%h",
                 p, lat, out_state, exps[p]);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      in_state4 = pats[p];
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 200) begin tick(); lat++; end
      n_tests++;
      if (lat !== 5 || out_state4 !== exps[p]) begin
        n_fail++;
        $display("FAIL pattern%0d_l4: got lat=%0d out=%h, required lat=5 out=%h",
                 p, lat, out_state4, exps[p]);
      end
      out_ready4 = 1'b1; tick(); out_ready4 = 1'b0;
      n_tests++;
      if ({out_valid4, in_ready4} !== 2'b01) begin
        n_fail++;
        $display("FAIL pattern%0d_l4_release: got vld/rdy=%b, required 01", p, {out_valid4, in_ready4});
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    logic [127:0] exp;
    send1(rand128());
    wait_out1(lat);
    exp = sb_q.pop_front();
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if ({out_valid, in_ready} !== 2'b10 || out_state !== exp) begin
        n_fail++; bad++;
        $display("FAIL backpressure_hold%0d: got vld/rdy=%b out=%h, required 10 out=%h",
                 c, {out_valid, in_ready}, out_state, exp);
      end
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL backpressure_release: got vld/rdy=%b, required 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_ignored_input();
    logic [127:0] a, b, exp;
    int lat;
    a = rand128();
    b = rand128();
    send1(a);
    in_state = b;
    in_valid = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_in_ready: got %b, required 0", in_ready);
    end
    wait_out1(lat);
    lat = lat + 1;
    exp = sb_q.pop_front();
    n_tests++;
    if (lat !== 17 || out_state !== exp) begin
      n_fail++;
      $display("FAIL ignored_first: got lat=%0d out=%h, required lat=17 out=%h", lat, out_state, exp);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_tests++;
    if ({in_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL ignored_not_in_done: got rdy/busy=%b, required 10", {in_ready, busy});
    end
    tick();
    in_valid = 1'b0;
    sb_q.push_back(ref_sub(b));
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ignored_second_accept: got busy=%b, required 1", busy);
    end
    wait_out1(lat);
    exp = sb_q.pop_front();
    n_tests++;
    if (lat !== 17 || out_state !== exp) begin
      n_fail++;
      $display("FAIL ignored_second: got lat=%0d out=%h, required lat=17 out=%h", lat, out_state, exp);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses = 0;
    logic [127:0] exp;
    send1(rand128());
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_q.delete();
    n_tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_state !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_mid_state: got rdy/vld/busy=%b out=%h, required 100 out=0",
               {in_ready, out_valid, busy}, out_state);
    end
    for (int c = 0; c < 20; c++) begin
      if (out_valid) pulses++;
      tick();
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_pulse: got %0d out_valid cycles, required 0", pulses);
    end
    send1(rand128());
    wait_out1(lat);
    exp = sb_q.pop_front();
    n_tests++;
    if (lat !== 17 || out_state !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_after: got lat=%0d out=%h, required lat=17 out=%h", lat, out_state, exp);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] cur, exp;
    int sent = 0, got = 0, cyc = 0, last_acc = -1;
    bit acc;
    out_ready = 1'b1;
    cur = rand128();
    in_state = cur;
    in_valid = 1'b1;
    while (got < 100 && cyc < 3000) begin
      acc = 1'b0;
      if (out_valid) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious: out_valid with no pending state at cycle %0d", cyc);
        end else begin
          exp = sb_q.pop_front();
          if (out_state !== exp) begin
            n_fail++;
            $display("FAIL b2b_value%0d: got %h, required %h", got, out_state, exp);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(ref_sub(cur));
        // DONE and IDLE each take one cycle between consecutive accepts.
        if (last_acc >= 0) begin
          n_tests++;
          if (cyc - last_acc !== N1 + 3) begin
            n_fail++;
            $display("FAIL b2b_period%0d: got %0d, required %0d", sent, cyc - last_acc, N1 + 3);
          end
        end
        last_acc = cyc;
        sent++;
        acc = 1'b1;
      end
      tick();
      cyc++;
      if (acc) begin
        if (sent < 100) begin
          cur = rand128();
          in_state = cur;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (got !== 100) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, required 100", got);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_fips();
    test_patterns();
    test_backpressure();
    test_ignored_input();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
